// File: rtl/fourier_meas_pkg.sv
// Shared types for the period meter: FSM states, the result record and a
// saturating counter step.
package fourier_meas_pkg;

  localparam int CNT_W_MAX = 32;

  typedef enum logic [1:0] {ACQ, SYNC, MEAS_HIGH, MEAS_LOW} meas_state_t;

  // Fields are sized for the widest supported counter; narrower instances
  // zero-extend into them.
  typedef struct packed {
    logic [CNT_W_MAX-1:0] period;
    logic [CNT_W_MAX-1:0] high;
    logic                 ovf;
  } meas_res_t;

  function automatic logic [CNT_W_MAX-1:0] sat_inc(input logic [CNT_W_MAX-1:0] v,
                                                   input int unsigned w);
    logic [CNT_W_MAX-1:0] lim;
    lim = (w >= CNT_W_MAX) ? '1 : CNT_W_MAX'((64'd1 << w) - 64'd1);
    return (v >= lim) ? lim : v + 1'b1;
  endfunction

endpackage

// File: rtl/hyst_slicer.sv
// Hysteresis slicer: keeps a registered level and flags edges on the sample
// that causes them, so the FSM can act in the same cycle.
module hyst_slicer #(
  parameter int DATA_W = 12,
  parameter int HYST   = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid,
  input  logic signed [DATA_W-1:0] data,
  output logic                     rise,
  output logic                     fall,
  output logic                     hit
);

  localparam logic signed [DATA_W-1:0] TH_HI = DATA_W'(HYST);
  localparam logic signed [DATA_W-1:0] TH_LO = DATA_W'(-HYST);

  logic level;
  logic hi, lo;

  assign hi   = valid && (data >= TH_HI);
  assign lo   = valid && (data <= TH_LO);
  assign hit  = hi || lo;
  // Before the level is known the FSM only looks at hit, so the reset
  // value of level never produces a counted edge.
  assign rise = hi && !level;
  assign fall = lo && level;

  always_ff @(posedge clk) begin
    if (rst)     level <= 1'b0;
    else if (hi) level <= 1'b1;
    else if (lo) level <= 1'b0;
  end

endmodule

// File: rtl/fourier_period_meter.sv
// Period / high-time meter: slicer, measurement FSM with saturating counters
// and a one-entry valid/ready result buffer.
module fourier_period_meter
  import fourier_meas_pkg::*;
#(
  parameter int DATA_W     = 12,
  parameter int CNT_W      = 16,
  parameter int HYST       = 64,
  parameter int MIN_PERIOD = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CNT_W-1:0]         out_period,
  output logic [CNT_W-1:0]         out_high,
  output logic                     out_overflow,
  output logic                     locked,
  output logic                     dropped
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  meas_state_t      state;
  logic [CNT_W-1:0] period_cnt, high_cnt;
  logic             ovf;
  logic             rise, fall, hit;
  logic [CNT_W-1:0] period_inc, high_inc;
  logic             period_max, high_max;
  logic             push;
  meas_res_t        push_res, res_q;

  hyst_slicer #(.DATA_W(DATA_W), .HYST(HYST)) u_slicer (
    .clk  (clk),
    .rst  (rst),
    .valid(in_valid),
    .data (in_data),
    .rise (rise),
    .fall (fall),
    .hit  (hit)
  );

  assign period_inc = CNT_W'(sat_inc(CNT_W_MAX'(period_cnt), CNT_W));
  assign high_inc   = CNT_W'(sat_inc(CNT_W_MAX'(high_cnt), CNT_W));
  assign period_max = (period_cnt == CNT_MAX);
  assign high_max   = (high_cnt == CNT_MAX);

  assign push     = rise && (state == MEAS_LOW) &&
                    (CNT_W_MAX'(period_cnt) >= CNT_W_MAX'(MIN_PERIOD));
  assign push_res = '{period: CNT_W_MAX'(period_cnt),
                      high:   CNT_W_MAX'(high_cnt),
                      ovf:    ovf};

  assign out_period   = CNT_W'(res_q.period);
  assign out_high     = CNT_W'(res_q.high);
  assign out_overflow = res_q.ovf;
  assign locked       = (state == MEAS_HIGH) || (state == MEAS_LOW);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ACQ;
      period_cnt <= '0;
      high_cnt   <= '0;
      ovf        <= 1'b0;
      res_q      <= '0;
      out_valid  <= 1'b0;
      dropped    <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      // A full buffer only takes the new result if the old one leaves now.
      if (push) begin
        if (!out_valid || out_ready) begin
          res_q     <= push_res;
          out_valid <= 1'b1;
        end else begin
          dropped <= 1'b1;
        end
      end

      if (in_valid) begin
        case (state)
          ACQ: if (hit) state <= SYNC;
          SYNC: begin
            if (rise) begin
              period_cnt <= CNT_W'(1);
              high_cnt   <= CNT_W'(1);
              ovf        <= 1'b0;
              state      <= MEAS_HIGH;
            end
          end
          MEAS_HIGH: begin
            period_cnt <= period_inc;
            if (fall) begin
              ovf   <= ovf | period_max;
              state <= MEAS_LOW;
            end else begin
              high_cnt <= high_inc;
              ovf      <= ovf | period_max | high_max;
            end
          end
          MEAS_LOW: begin
            if (rise) begin
              period_cnt <= CNT_W'(1);
              high_cnt   <= CNT_W'(1);
              ovf        <= 1'b0;
              state      <= MEAS_HIGH;
            end else begin
              period_cnt <= period_inc;
              ovf        <= ovf | period_max;
            end
          end
          default: state <= ACQ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fourier_period_meter.sv
// Directed bench: a 16-bit and a 4-bit counter instance share one stimulus
// stream; a behavioural edge-index model fills a one-deep scoreboard.
module tb_fourier_period_meter;

  localparam int DATA_W     = 12;
  localparam int HYST       = 64;
  localparam int MIN_PERIOD = 4;

  logic clk = 1'b0;
  logic rst, in_valid, out_ready;
  logic signed [DATA_W-1:0] in_data;

  logic        va, oa, la, da;
  logic [15:0] pa, ha;
  logic        vb, ob, lb, db;
  logic [3:0]  pb, hb;

  always #5 clk = ~clk;

  fourier_period_meter #(.DATA_W(DATA_W), .CNT_W(16), .HYST(HYST), .MIN_PERIOD(MIN_PERIOD)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .out_valid(va), .out_ready(out_ready), .out_period(pa), .out_high(ha),
    .out_overflow(oa), .locked(la), .dropped(da));

  fourier_period_meter #(.DATA_W(DATA_W), .CNT_W(4), .HYST(HYST), .MIN_PERIOD(MIN_PERIOD)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .out_valid(vb), .out_ready(out_ready), .out_period(pb), .out_high(hb),
    .out_overflow(ob), .locked(lb), .dropped(db));

  typedef struct {int per; int hi;} exp_t;
  exp_t q[$];

  int checks = 0;
  int errors = 0;

  int m_idx, m_rise_idx, m_fall_idx;
  bit m_known, m_level, m_have_rise, m_dropped;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int satv(input int v, input int w);
    int m;
    m = (1 << w) - 1;
    return (v > m) ? m : v;
  endfunction

  task automatic model_reset();
    q.delete();
    m_idx = 0; m_rise_idx = 0; m_fall_idx = 0;
    m_known = 0; m_level = 0; m_have_rise = 0; m_dropped = 0;
  endtask

  task automatic model_sample(input int d);
    bit hi, lo;
    int per, h;
    m_idx++;
    hi = (d >= HYST);
    lo = (d <= -HYST);
    if (!m_known) begin
      if (hi || lo) begin
        m_known = 1;
        m_level = hi;
      end
    end else if (hi && !m_level) begin
      m_level = 1;
      if (m_have_rise) begin
        per = m_idx - m_rise_idx;
        h   = m_fall_idx - m_rise_idx;
        if (per >= MIN_PERIOD) begin
          if (q.size() == 0) q.push_back('{per, h});
          else m_dropped = 1;
        end
      end
      m_have_rise = 1;
      m_rise_idx  = m_idx;
    end else if (lo && m_level) begin
      m_level    = 0;
      m_fall_idx = m_idx;
    end
  endtask

  task automatic check_outputs();
    bit v;
    v = (q.size() != 0);
    chk("valid16", 32'(va), 32'(v));
    chk("valid4", 32'(vb), 32'(v));
    chk("locked16", 32'(la), 32'(m_have_rise));
    chk("locked4", 32'(lb), 32'(m_have_rise));
    chk("dropped16", 32'(da), 32'(m_dropped));
    chk("dropped4", 32'(db), 32'(m_dropped));
    if (v) begin
      chk("period16", 32'(pa), satv(q[0].per, 16));
      chk("high16", 32'(ha), satv(q[0].hi, 16));
      chk("ovf16", 32'(oa), 32'(q[0].per > 65535 || q[0].hi > 65535));
      chk("period4", 32'(pb), satv(q[0].per, 4));
      chk("high4", 32'(hb), satv(q[0].hi, 4));
      chk("ovf4", 32'(ob), 32'(q[0].per > 15 || q[0].hi > 15));
    end
  endtask

  task automatic step(input logic v, input int d, input logic rdy);
    check_outputs();
    in_valid  = v;
    in_data   = DATA_W'(d);
    out_ready = rdy;
    if (q.size() != 0 && rdy) void'(q.pop_front());
    if (v) model_sample(d);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wave(input int nper, input int hl, input int ll, input logic rdy);
    for (int p = 0; p < nper; p++) begin
      for (int i = 0; i < hl; i++) step(1'b1, 500, rdy);
      for (int i = 0; i < ll; i++) step(1'b1, -500, rdy);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    chk("rst_valid", 32'(va), 0);
    chk("rst_period", 32'(pa), 0);
    chk("rst_high", 32'(ha), 0);
    chk("rst_ovf", 32'(oa), 0);
    chk("rst_locked", 32'(la), 0);
    chk("rst_dropped", 32'(da), 0);
    chk("rst_valid4", 32'(vb), 0);
    chk("rst_period4", 32'(pb), 0);
    chk("rst_locked4", 32'(lb), 0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    model_reset();
    @(negedge clk);
    do_reset();

    // steady wave, period 10 / high 5
    wave(5, 5, 5, 1'b1);
    chk("steady_locked", 32'(la), 1);

    // noisy wave, period 12 / high 6, with in-band spikes and input gaps
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 6; i++) begin
        step(1'b1, (i % 2) ? 530 : 470, 1'b1);
        if (i == 2) step(1'b0, -500, 1'b1);
      end
      for (int i = 0; i < 6; i++) begin
        step(1'b1, (i == 3) ? 40 : ((i % 2) ? -470 : -530), 1'b1);
        if (i == 1) step(1'b0, 500, 1'b1);
      end
    end

    // glitch inside a low phase
    wave(1, 5, 5, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 500, 1'b1);
    step(1'b1, -500, 1'b1);
    step(1'b1, -500, 1'b1);
    step(1'b1, 500, 1'b1);
    step(1'b1, -500, 1'b1);
    step(1'b1, -500, 1'b1);
    wave(3, 5, 5, 1'b1);

    // backpressure: hold, drop, then replace on a ready push cycle
    wave(2, 5, 5, 1'b0);
    chk("bp_dropped", 32'(da), 1);
    step(1'b1, 500, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 500, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, -500, 1'b0);
    step(1'b1, 500, 1'b1);
    chk("bp_valid_kept", 32'(va), 1);
    wave(2, 5, 5, 1'b1);

    // long periods saturate the 4-bit instance
    wave(3, 20, 20, 1'b1);
    step(1'b1, 500, 1'b0);
    chk("sat_period4", 32'(pb), 15);
    chk("sat_high4", 32'(hb), 15);
    chk("sat_ovf4", 32'(ob), 1);
    chk("sat_period16", 32'(pa), 40);
    wave(1, 5, 5, 1'b1);

    // reset inside MEAS_LOW with a result buffered
    wave(1, 5, 5, 1'b0);
    chk("pre_rst_valid", 32'(va), 1);
    do_reset();
    wave(4, 5, 5, 1'b1);

    check_outputs();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
